hilo_issue_ctrl: RTL

//  Requester-side controller for the HI/LO mult/div unit. Sits in the E stage.

---
 rtl/hilo_issue_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/hilo_issue_ctrl.sv
// Requester-side issue controller for the HI/LO mult/div unit (E stage).
// Drives start/from, tracks unit occupancy, stalls D on HI/LO hazards, watchdogs a stuck unit.
module hilo_issue_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_op,
  input  logic [3:0] e_op,
  input  logic       e_valid,
  input  logic       req,
  input  logic       isbusy,
  output logic [3:0] start,
  output logic [1:0] from,
  output logic       stall,
  output logic       md_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUED = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;

  localparam logic [3:0] OP_MFHI = 4'b0110;
  localparam logic [3:0] OP_MFLO = 4'b1000;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WD_SAT  = CNT_W'(MAX_WAIT);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wd_cnt, wd_nxt;
  logic             err_nxt;
  logic             e_start;
  logic             unit_done;

  // Issue is purely combinational: an exception request in E squashes the op.
  assign start     = (e_valid && !req) ? e_op : 4'b0000;
  assign e_start   = start[0];
  assign from      = (start == OP_MFHI || start == OP_MFLO) ? 2'b11 : 2'b00;
  assign stall     = (d_op != 4'b0000) &&
                     (e_start || state == ISSUED || (state == BUSY && isbusy));
  assign unit_done = (state == BUSY) && !isbusy;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd_cnt;
    err_nxt   = md_err;
    if (state == IDLE) begin
      // The issue cycle itself counts toward the watchdog window.
      wd_nxt = '0;
      if (e_start) begin
        state_nxt = ISSUED;
        wd_nxt    = CNT_W'(1);
      end
    end else if (unit_done) begin
      state_nxt = IDLE;
      wd_nxt    = '0;
    end else if (wd_cnt >= WD_LAST) begin
      state_nxt = IDLE;
      wd_nxt    = WD_SAT;
      err_nxt   = 1'b1;
    end else begin
      state_nxt = BUSY;
      wd_nxt    = wd_cnt + CNT_W'(1);
    end
    // A new long op while the unit is occupied means D was not stalled properly.
    if (e_start && state != IDLE) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wd_cnt <= '0;
      md_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      md_err <= err_nxt;
    end
  end

endmodule
